// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down sweep sequencer and its counter datapath.
package updown_pkg;

  localparam int unsigned WIDTH_DEF = 3;
  localparam int unsigned SW_W_DEF  = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/updown_core.sv
// WIDTH-bit up/down counter: load has priority over counting; en gates the step in direction u.
module updown_core
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             u_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = d_i;
    end else if (en_i) begin
      cnt_d = (u_i == DIR_UP) ? WIDTH'(cnt_q + WIDTH'(1)) : WIDTH'(cnt_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: runs the counter lo->hi->lo for a latched number of round trips,
// with start/busy/done handshake, bound checking and abort.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SW_W  = SW_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [SW_W-1:0]  sweeps_i,
  output logic [WIDTH-1:0] out_o,
  output logic             u_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  logic             u_q, u_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic [SW_W-1:0]  sw_dec;
  logic             load_c;
  logic             en_c;
  logic [WIDTH-1:0] count;

  updown_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_c),
    .d_i     (lo_i),
    .en_i    (en_c),
    .u_i     (u_q),
    .q_o     (count)
  );

  // Decisions look at the counter's next value so the turn happens on the edge it lands on a bound.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sw_d    = sw_q;
    load_c  = 1'b0;
    en_c    = 1'b0;
    sw_dec  = SW_W'(sw_q - SW_W'(1));

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (lo_i > hi_i) begin
            err_d = 1'b1;
          end else begin
            load_c = 1'b1;
            lo_d   = lo_i;
            hi_d   = hi_i;
            sw_d   = sweeps_i;
            if ((sweeps_i == '0) || (lo_i == hi_i)) begin
              state_d = FIN;
            end else begin
              state_d = UP;
              u_d     = DIR_UP;
              busy_d  = 1'b1;
            end
          end
        end
      end
      UP: begin
        if (abort_i) begin
          state_d = IDLE;
          u_d     = DIR_DN;
          busy_d  = 1'b0;
        end else begin
          en_c = 1'b1;
          if (WIDTH'(count + WIDTH'(1)) == hi_q) begin
            state_d = DOWN;
            u_d     = DIR_DN;
          end
        end
      end
      DOWN: begin
        if (abort_i) begin
          state_d = IDLE;
          u_d     = DIR_DN;
          busy_d  = 1'b0;
        end else begin
          en_c = 1'b1;
          if (WIDTH'(count - WIDTH'(1)) == lo_q) begin
            sw_d = sw_dec;
            if (sw_dec == '0) begin
              state_d = FIN;
            end else begin
              state_d = UP;
              u_d     = DIR_UP;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      u_q     <= DIR_DN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sw_q    <= sw_d;
    end
  end

  assign out_o  = count;
  assign u_o    = u_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: hand table of runs, corner sequences, and random traffic
// checked every cycle against a trace-based reference model.
module tb_updown_sweep_ctrl;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_ACT  = 2'd1;
  localparam logic [1:0] C_FIN  = 2'd2;

  typedef struct packed {
    logic [2:0] out;
    logic       u;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] cls;
  } obs_t;

  typedef struct {
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] sw;
    int         done_edge;
    int         err_edge;
    int         busy_ever;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] lo;
  logic [2:0] hi;
  logic [3:0] sweeps;
  logic [2:0] out_o;
  logic       u_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t cur;
  obs_t trace_q[$];
  vec_t vecs[8];

  updown_sweep_ctrl dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .abort_i  (abort),
    .lo_i     (lo),
    .hi_i     (hi),
    .sweeps_i (sweeps),
    .out_o    (out_o),
    .u_o      (u_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic obs_t mk(input int v, input logic uu, input logic b, input logic d,
                              input logic e, input logic [1:0] c);
    obs_t o;
    o.out  = 3'(v);
    o.u    = uu;
    o.busy = b;
    o.done = d;
    o.err  = e;
    o.cls  = c;
    return o;
  endfunction

  // Expected output trace of an accepted run: positions visited, then the done cycle.
  task automatic build_run(input logic [2:0] l, input logic [2:0] h, input logic [3:0] s);
    int pos[$];
    if (s == 4'd0 || l == h) begin
      trace_q.push_back(mk(int'(l), 1'b0, 1'b0, 1'b0, 1'b0, C_FIN));
    end else begin
      pos.push_back(int'(l));
      for (int k = 0; k < int'(s); k++) begin
        for (int v = int'(l) + 1; v <= int'(h); v++) pos.push_back(v);
        for (int v = int'(h) - 1; v >= int'(l); v--) pos.push_back(v);
      end
      for (int i = 0; i < pos.size(); i++) begin
        if (i == pos.size() - 1) trace_q.push_back(mk(pos[i], 1'b0, 1'b1, 1'b0, 1'b0, C_FIN));
        else trace_q.push_back(mk(pos[i], pos[i+1] > pos[i], 1'b1, 1'b0, 1'b0, C_ACT));
      end
    end
    trace_q.push_back(mk(int'(l), 1'b0, 1'b0, 1'b1, 1'b0, C_IDLE));
  endtask

  task automatic model_edge(input logic st, input logic ab, input logic [2:0] l,
                            input logic [2:0] h, input logic [3:0] s);
    if (cur.cls == C_IDLE) begin
      if (st && !ab) begin
        if (l > h) cur = mk(int'(cur.out), 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE);
        else begin
          build_run(l, h, s);
          cur = trace_q.pop_front();
        end
      end else begin
        cur = mk(int'(cur.out), 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
      end
    end else if (cur.cls == C_ACT && ab) begin
      trace_q.delete();
      cur = mk(int'(cur.out), 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
    end else if (trace_q.size() > 0) begin
      cur = trace_q.pop_front();
    end else begin
      cur = mk(int'(cur.out), 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at following negedge.
  task automatic step(input logic st, input logic ab, input logic [2:0] l,
                      input logic [2:0] h, input logic [3:0] s);
    start  = st;
    abort  = ab;
    lo     = l;
    hi     = h;
    sweeps = s;
    @(posedge clk);
    model_edge(st, ab, l, h, s);
    @(negedge clk);
    chk("trace{out,u,busy,done,err}", int'({out_o, u_o, busy_o, done_o, err_o}),
        int'({cur.out, cur.u, cur.busy, cur.done, cur.err}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
  endtask

  initial begin
    int lbl, got_done, got_err, busy_seen, mx, mn, ndone;
    vecs[0] = '{lo: 3'd1, hi: 3'd4, sw: 4'd1,  done_edge: 8,  err_edge: 0, busy_ever: 1};
    vecs[1] = '{lo: 3'd0, hi: 3'd7, sw: 4'd2,  done_edge: 30, err_edge: 0, busy_ever: 1};
    vecs[2] = '{lo: 3'd5, hi: 3'd2, sw: 4'd1,  done_edge: 0,  err_edge: 1, busy_ever: 0};
    vecs[3] = '{lo: 3'd3, hi: 3'd3, sw: 4'd3,  done_edge: 2,  err_edge: 0, busy_ever: 0};
    vecs[4] = '{lo: 3'd2, hi: 3'd6, sw: 4'd0,  done_edge: 2,  err_edge: 0, busy_ever: 0};
    vecs[5] = '{lo: 3'd6, hi: 3'd7, sw: 4'd3,  done_edge: 8,  err_edge: 0, busy_ever: 1};
    vecs[6] = '{lo: 3'd0, hi: 3'd1, sw: 4'd15, done_edge: 32, err_edge: 0, busy_ever: 1};
    vecs[7] = '{lo: 3'd7, hi: 3'd7, sw: 4'd0,  done_edge: 2,  err_edge: 0, busy_ever: 0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; sweeps = '0;
    cur = mk(0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", int'({out_o, u_o, busy_o, done_o, err_o}), 0);
    reset = 1'b0;
    idle(2);

    // Table of runs with hand-derived done/err edges and sweep extremes.
    foreach (vecs[r]) begin
      got_done = 0; got_err = 0; busy_seen = 0; mx = -1; mn = 8;
      step(1'b1, 1'b0, vecs[r].lo, vecs[r].hi, vecs[r].sw);
      lbl = 1;
      forever begin
        if (done_o && got_done == 0) got_done = lbl;
        if (err_o && got_err == 0) got_err = lbl;
        if (busy_o) begin
          busy_seen = 1;
          if (int'(out_o) > mx) mx = int'(out_o);
          if (int'(out_o) < mn) mn = int'(out_o);
        end
        if (got_done != 0 || got_err != 0 || lbl >= 200) break;
        step(1'b0, 1'b0, vecs[r].lo, vecs[r].hi, vecs[r].sw);
        lbl++;
      end
      chk($sformatf("row%0d_done_edge", r), got_done, vecs[r].done_edge);
      chk($sformatf("row%0d_err_edge", r), got_err, vecs[r].err_edge);
      chk($sformatf("row%0d_busy_ever", r), busy_seen, vecs[r].busy_ever);
      if (vecs[r].busy_ever != 0) begin
        chk($sformatf("row%0d_max_out", r), mx, int'(vecs[r].hi));
        chk($sformatf("row%0d_min_out", r), mn, int'(vecs[r].lo));
      end
      idle(2);
    end

    // Asynchronous reset while sweeping up at out=3.
    step(1'b1, 1'b0, 3'd0, 3'd7, 4'd1);
    idle(3);
    chk("pre_reset_out", int'(out_o), 3);
    reset = 1'b1;
    #1;
    chk("async_rst_out", int'(out_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_u", int'(u_o), 0);
    trace_q.delete();
    cur = mk(0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (done_o) ndone++;
    end
    chk("rst_no_done", ndone, 0);

    // Abort at out=3 while sweeping down; a start issued while busy is ignored.
    step(1'b1, 1'b0, 3'd1, 3'd5, 4'd2);
    idle(1);
    step(1'b1, 1'b0, 3'd0, 3'd2, 4'd1);
    chk("busy_start_out", int'(out_o), 3);
    chk("busy_start_busy", int'(busy_o), 1);
    idle(4);
    chk("pre_abort_out", int'(out_o), 3);
    chk("pre_abort_u", int'(u_o), 0);
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0);
    chk("abort_out", int'(out_o), 3);
    chk("abort_busy", int'(busy_o), 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (done_o) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // start together with abort in IDLE is dropped.
    step(1'b1, 1'b1, 3'd2, 3'd5, 4'd1);
    idle(1);
    chk("start_abort_busy", int'(busy_o), 0);
    chk("start_abort_out", int'(out_o), 3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the 3-bit up/down counter datapath: sweeps the count between programmable bounds `lo` and `hi` (up to `hi`, back down to `lo`) for a programmed number of round trips. It owns the direction line `u`, provides a start/busy/done handshake to the host, and rejects illegal bound settings. It sits between host control logic and the counter, and is the only driver of the counter's direction and load.

## Interface
- `WIDTH`, 3: counter width.
- `SW_W`, 4: sweep-count width.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request, sampled only in IDLE.
- `abort` in 1: synchronous abort of an active run.
- `lo` in WIDTH: lower bound, captured on accepted `start`.
- `hi` in WIDTH: upper bound, captured on accepted `start`.
- `sweeps` in SW_W: round-trip count, captured on accepted `start`.
- `out` out WIDTH: current count.
- `u` out 1: direction, 1 = up, 0 = down.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when a run completes normally.
- `err` out 1: one-cycle pulse when a `start` is rejected.

## Operation
- Reset values: `out`=0, `u`=0, `busy`=0, `done`=0, `err`=0, state IDLE, sweep counter 0.
- States are IDLE, UP, DOWN and FIN.
- **IDLE:**
  - `start` with `lo > hi`: pulse `err`, stay IDLE, `out` unchanged.
  - `start` with `sweeps == 0` or `lo == hi`: load `out`=`lo`, go to FIN.
  - Other `start`: latch `lo`, `hi` and `sweeps`; load `out`=`lo`; set `u`=1, `busy`=1; go to UP.
- **UP:** `out` increments by 1 per cycle. When `out` becomes `hi`, next state is DOWN and `u`=0.
- **DOWN:** `out` decrements by 1 per cycle. When `out` becomes `lo`:
  - decrement the remaining sweep count;
  - if the result is 0, go to FIN;
  - otherwise go to UP with `u`=1.
- **FIN:** `done`=1 for one cycle, `busy`=0, `out` holds, then go to IDLE.
- **Arithmetic:** unsigned WIDTH-bit. Because bounds are enforced, `out` never wraps past 7 or below 0.
- **Inputs during a run:** `start` while `busy` is ignored. Changes to `lo`, `hi` or `sweeps` while `busy` have no effect (latched copies are used).
- **`abort`:**
  - In UP or DOWN: next state IDLE, `busy`=0, `u`=0, `out` holds, no `done` pulse.
  - In IDLE: `abort` with `start` in the same cycle means `start` is ignored.
  - In FIN: `abort` has no effect and `done` still pulses.
- **Reset mid-run:** returns all outputs to their reset values immediately (asynchronous).

## Timing
- All outputs are registered. Edge k means the k-th rising edge after `start` is sampled at edge 0.
- Edge 1: `out`=`lo`, `busy`=1, `u`=1.
- `out` reaches `hi` at edge 1+(hi−lo).
- One round trip takes 2·(hi−lo) cycles. The final return to `lo` occurs at edge 1+2·sweeps·(hi−lo).
- `done` is high for the single cycle after the final return; `busy` is low in that same cycle.
- Degenerate runs (`sweeps` = 0 or `lo` = `hi`): `done` at edge 2, and `busy` never rises.
- `err` is high for the cycle following edge 0.

## Structure
- Shared package `updown_pkg` holds:
  - the state enum (IDLE, UP, DOWN, FIN);
  - `WIDTH` and `SW_W` defaults;
  - the direction constants UP=1 and DN=0.
- Sub-module `updown_core` is the datapath: WIDTH-bit up/down counter with ports `clk`, `reset`, `load`, `d`, `en` and `u`. The controller instantiates it and drives `load`, `en` and `u`.
- The FSM and the sweep counter live in the top module.

## Test plan
- Reset asserted mid-UP at `out`=3 → `out`=0, `busy`=0, `u`=0 immediately. Release, then idle → no `done`.
- `lo`=1, `hi`=4, `sweeps`=1 → `out` sequence 1,2,3,4,3,2,1 at edges 1–7, `u` falls at edge 4, `done` at edge 8.
- `lo`=0, `hi`=7, `sweeps`=2 → two full 0↔7 trips, `done` at edge 30, no wrap observed.
- `lo`=5, `hi`=2 with `start` → `err` pulse for one cycle, `busy` stays 0, `out` unchanged.
- `lo`=`hi`=3 with `start` → `out`=3, `done` at edge 2, `busy` never 1. `sweeps`=0 behaves the same way.
- `abort` at `out`=3 during DOWN → IDLE, `out` holds 3, no `done`. A second `start` issued while `busy` is ignored. `start` together with `abort` in IDLE is ignored.
